// File: rtl/scroll_msg_buffer.sv
// Message store and scroll sequencer for an 8-digit seven-segment display.
// Characters are written over a valid/ready port; a registered 8-digit window advances one position per tick.
module scroll_msg_buffer #(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 100_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   wr_valid,
  input  logic [4:0]             wr_char,
  output logic                   wr_ready,
  input  logic                   run,
  output logic [63:0]            seg_bus,
  output logic [$clog2(DEPTH):0] len,
  output logic                   scrolling,
  output logic                   wrap,
  output logic [1:0]             fsm_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 8);
  localparam int CW = $clog2(TICK_DIV);

  localparam logic [1:0] EMPTY  = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] SCROLL = 2'd2;

  logic [4:0]    mem [DEPTH];
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [OW-1:0] offset;
  logic [OW-1:0] last_pos;
  logic [CW-1:0] presc;
  logic          accept;
  logic          tick;
  logic          at_end;
  logic [63:0]   window;

  // Write handshake: a write transfers on a clock edge where wr_valid and wr_ready are both high.
  assign wr_ready  = (len != (AW + 1)'(DEPTH)) & ~clr;
  assign accept    = wr_valid & wr_ready;
  assign scrolling = (state == SCROLL);
  assign fsm_state = state;
  assign last_pos  = OW'(len) + OW'(7);
  assign at_end    = (offset == last_pos);
  assign tick      = (state == SCROLL) && (state_nxt == SCROLL) &&
                     (presc == CW'(TICK_DIV - 1));

  function automatic logic [7:0] enc(input logic [4:0] c);
    case (c)
      5'd0:  enc = 8'hFC;  5'd1:  enc = 8'h60;  5'd2:  enc = 8'hDA;  5'd3:  enc = 8'hF2;
      5'd4:  enc = 8'h66;  5'd5:  enc = 8'hB6;  5'd6:  enc = 8'hBE;  5'd7:  enc = 8'hE0;
      5'd8:  enc = 8'hFE;  5'd9:  enc = 8'hF6;  5'd10: enc = 8'hEE;  5'd11: enc = 8'h3E;
      5'd12: enc = 8'h9C;  5'd13: enc = 8'h7A;  5'd14: enc = 8'h9E;  5'd15: enc = 8'h8E;
      5'd17: enc = 8'h02;  5'd18: enc = 8'h6E;  5'd19: enc = 8'h1C;  5'd20: enc = 8'hCE;
      5'd21: enc = 8'h7C;  5'd22: enc = 8'h0A;  5'd23: enc = 8'h2A;  5'd24: enc = 8'h3A;
      default: enc = 8'h00;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:        if (accept) state_nxt = run ? SCROLL : HOLD;
        HOLD, SCROLL: state_nxt = run ? SCROLL : HOLD;
        default:      state_nxt = EMPTY;
      endcase
    end
  end

  // Positions past the stored message are the trailing blanks of the virtual sequence.
  always_comb begin
    window = '0;
    for (int i = 0; i < 8; i++) begin
      if ((OW + 1)'(offset) + (OW + 1)'(i) < (OW + 1)'(len))
        window[63 - 8*i -: 8] = enc(mem[AW'(offset + OW'(i))]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) mem[len[AW-1:0]] <= wr_char;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state   <= EMPTY;
      len     <= '0;
      offset  <= '0;
      presc   <= '0;
      wrap    <= 1'b0;
      seg_bus <= '0;
    end else begin
      state   <= state_nxt;
      seg_bus <= window;
      wrap    <= tick & at_end;
      if (accept) len <= len + 1'b1;
      // Any entry to or exit from SCROLL discards the partial step.
      if (state != SCROLL || state_nxt != SCROLL)
        presc <= '0;
      else if (tick)
        presc <= '0;
      else
        presc <= presc + 1'b1;
      if (tick) offset <= at_end ? '0 : offset + 1'b1;
    end
  end

endmodule

// File: doc/scroll_msg_buffer.md
# scroll_msg_buffer

Message buffer and scroll sequencer feeding the 8-digit seven-segment scan driver. It accepts character codes over a valid/ready write port and stores up to DEPTH characters. It encodes them to segment patterns and presents an 8-digit window that advances one position per scroll tick. The scan driver consumes `seg_bus` and performs digit multiplexing; this block does no scanning.

## Interface
- DEPTH, 16: message capacity in characters; power of 2, 8 to 64.
- TICK_DIV, 100_000_000: clk cycles per scroll step (1 s at 100 MHz); at least 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clr`  in  1  synchronous clear: empty the buffer and stop scrolling.
- `wr_valid`  in  1  write request.
- `wr_char`  in  5  character code.
- `wr_ready`  out  1  buffer can accept a write; `= (len != DEPTH) & ~clr`.
- `run`  in  1  level; 1 enables scrolling.
- `seg_bus`  out  64  registered segment patterns. Digit 0 (leftmost) is [63:56] and digit 7 is [7:0]. Each byte is {a,b,c,d,e,f,g,dp}, active high.
- `len`  out  $clog2(DEPTH)+1  number of stored characters.
- `scrolling`  out  1  1 while in state SCROLL.
- `wrap`  out  1  one-cycle pulse when the window offset returns to 0.

## Operation
- Encoding (code -> byte):
  - Hex digits: 0:FC 1:60 2:DA 3:F2 4:66 5:B6 6:BE 7:E0 8:FE 9:F6 A:EE B:3E C:9C D:7A E:9E F:8E.
  - Symbols and letters: 16 blank:00, 17 '-':02, 18 H:6E, 19 L:1C, 20 P:CE, 21 U:7C, 22 r:0A, 23 n:2A, 24 o:3A.
  - Codes 25-31 encode as 00.
- Write: when `wr_valid & wr_ready`, the character is stored at index `len` and `len` increments. Writes are legal in every state. When the buffer is full, the write is dropped.
- Virtual sequence: the message followed by 8 blanks, length V = len+8. Digit i shows the char at position offset+i if that position is < len, else blank.
- States:
  - EMPTY: len=0.
  - HOLD: len>0 and run=0; offset frozen.
  - SCROLL: len>0 and run=1.
- Transitions:
  - EMPTY->HOLD/SCROLL on the first accepted write, per `run`.
  - HOLD<->SCROLL follows `run`.
  - Any state->EMPTY on `clr` or `rst`.
- Prescaler:
  - Counts only in SCROLL and clears to 0 on every SCROLL entry or exit.
  - At count TICK_DIV-1 it raises a tick and returns to 0.
- Tick handling: if offset == V-1, offset goes to 0 and `wrap`=1 for that cycle. Otherwise offset increments.
- Offset range:
  - Offset is never ≥ V.
  - When a write grows V, the current offset is kept.
  - `clr` forces offset to 0.
- `clr` has priority over a simultaneous write; that write is dropped.
- `run`=1 while EMPTY: state stays EMPTY and the prescaler stays 0.

## Timing
- Reset values: `seg_bus`=0, `len`=0, `scrolling`=0, `wrap`=0, `wr_ready`=1 (once `rst` is released), offset=0, prescaler=0, state EMPTY.
- `wr_ready` is combinational from `len` and `clr`. No combinational path exists from `wr_valid` to `wr_ready`.
- Write accepted at edge k: `len` updates at edge k. `seg_bus` reflects the new char at edge k+1.
- Tick at edge k (offset changes, `wrap` asserted): `seg_bus` shows the new window at edge k+1.
- First tick after SCROLL entry: exactly TICK_DIV cycles after the edge that registers `scrolling`=1.
- `run` deasserted mid-step: the partial count is discarded. Re-entry restarts the full TICK_DIV period.
- `rst` or `clr` mid-scroll: all state matches reset at that edge. `seg_bus`=0 at the following edge.

## Test plan
- Reset: assert `rst` 3 cycles with `wr_valid`=1 -> `len`=0, `seg_bus`=0, `wrap`=0, `wr_ready`=1; no write accepted.
- Load "HELL0" (codes 18,14,19,19,0), `run`=0 -> `len`=5, state HOLD. `seg_bus`=64'h6E9E1C1CFC000000 and stays constant for 1000 cycles.
- TICK_DIV=4, `run`=1 after the load:
  - First tick: `seg_bus`=64'h9E1C1CFC00000000.
  - After 13 ticks: offset 0, `wrap` high exactly 1 cycle, `seg_bus` back to 64'h6E9E1C1CFC000000.
- Full: write 16 codes back-to-back, then assert `wr_valid` -> `wr_ready`=0 after the 16th write, `len`=16, 17th char absent from every window.
- `clr` and `wr_valid` in the same cycle while SCROLL -> `len`=0, `scrolling`=0, next `seg_bus`=0; the written char never appears.
- TICK_DIV=4: drop `run` 2 cycles into a step, re-raise 5 cycles later -> offset unchanged; the next tick comes 4 cycles after re-entry.
